// File: rtl/tlc_pkg.sv
// tlc_pkg: phase and lamp encodings shared by the multi-way traffic light controller.
package tlc_pkg;
    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_YELLOW = 2'd1;
    localparam logic [1:0] PH_ALLRED = 2'd2;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
endpackage

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick: first requester after cur (cur+1, cur+2, ... wrapping); valid means some other way requests.
module tlc_rr_pick #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] cur,
    output logic [AW-1:0] next,
    output logic          valid
);
    always_comb begin
        next = cur;
        valid = 1'b0;
        // Descending scan so the nearest requester after cur is the last writer.
        for (int k = N - 1; k >= 1; k--) begin
            if (req[(int'(cur) + k) % N]) begin
                next = AW'((int'(cur) + k) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tlc_multiway.sv
// tlc_multiway: round-robin N-approach traffic light controller with tick-based phase timing.
// Optional emergency preemption (emg_req/emg_way) is built when TLC_PREEMPT_EN is defined.
module tlc_multiway
    import tlc_pkg::*;
#(
    parameter int N_WAYS    = 4,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 6,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
`ifdef TLC_PREEMPT_EN
    input  logic                      emg_req,
    input  logic [$clog2(N_WAYS)-1:0] emg_way,
`endif
    input  logic [N_WAYS-1:0]         sensor,
    output logic [3*N_WAYS-1:0]       lights,
    output logic [$clog2(N_WAYS)-1:0] active_way,
    output logic [1:0]                phase
);
    localparam int AW = $clog2(N_WAYS);

    logic [TW-1:0] timer;
    logic [AW-1:0] target, pick, act_nxt, tgt_nxt;
    logic [1:0]    ph_nxt;
    logic          other_req, go_yellow;

    tlc_rr_pick #(.N(N_WAYS), .AW(AW)) u_pick (
        .req(sensor),
        .cur(active_way),
        .next(pick),
        .valid(other_req)
    );

    assign go_yellow = tick && timer >= TW'(MIN_GREEN - 1) && other_req
                       && (!sensor[active_way] || timer >= TW'(MAX_GREEN - 1));

    always_comb begin
        ph_nxt = phase;
        act_nxt = active_way;
        tgt_nxt = target;
        case (phase)
            PH_GREEN: if (go_yellow) begin
                ph_nxt = PH_YELLOW;
                tgt_nxt = pick;
            end
            PH_YELLOW: if (tick && timer == TW'(YELLOW_T - 1)) ph_nxt = PH_ALLRED;
            PH_ALLRED: if (tick && timer == TW'(ALLRED_T - 1)) begin
                ph_nxt = PH_GREEN;
                act_nxt = target;
            end
            default: ph_nxt = PH_GREEN;
        endcase
`ifdef TLC_PREEMPT_EN
        // Emergency overrides green immediately but lets yellow/all-red run their full length.
        if (emg_req) begin
            if (phase == PH_GREEN) begin
                ph_nxt = active_way == emg_way ? PH_GREEN : PH_YELLOW;
                tgt_nxt = active_way == emg_way ? target : emg_way;
            end else begin
                tgt_nxt = emg_way;
                act_nxt = (phase == PH_ALLRED && ph_nxt == PH_GREEN) ? emg_way : act_nxt;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_GREEN;
            active_way <= '0;
            target <= '0;
            timer <= '0;
        end else begin
            phase <= ph_nxt;
            active_way <= act_nxt;
            target <= tgt_nxt;
            timer <= ph_nxt != phase ? '0 : (tick && timer != '1) ? timer + 1'b1 : timer;
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < N_WAYS; i++)
            lights[3*i +: 3] = (AW'(i) == active_way && phase != PH_ALLRED)
                               ? (phase == PH_GREEN ? LAMP_GREEN : LAMP_YELLOW) : LAMP_RED;
    end
endmodule

// File: doc/tlc_multiway.md
Name: tlc_multiway

Overview:
Parametrised N-approach traffic light controller. It is the successor to the two-road highway/farm controller.
- Approaches are served round-robin among those whose vehicle sensor is asserted.
- Each approach has programmable minimum-green, maximum-green, yellow and all-red clearance times, counted in ticks of an external timebase enable.
- Sits between the sensor-conditioning logic and the lamp drivers.

Parameters:
N_WAYS, 4, number of approaches (>=2)
TW, 8, phase timer width in bits
MIN_GREEN, 3, minimum green duration in ticks (>=1)
MAX_GREEN, 6, maximum green when other approaches are waiting (>=MIN_GREEN, < 2**TW)
YELLOW_T, 2, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance duration in ticks (>=1)

Ports:
clk  in  1  clock; one clock domain, all logic on its rising edge
rst  in  1  reset; synchronous, active-high
tick  in  1  timebase enable; timers advance only on cycles with tick=1
sensor  in  N_WAYS  per-approach vehicle request, level-sensitive, sampled every cycle
lights  out  3*N_WAYS  per-approach lamp, field i = lights[3i+2:3i], {red,yellow,green}, one-hot
active_way  out  $clog2(N_WAYS)  approach currently owning green/yellow
phase  out  2  0=GREEN, 1=YELLOW, 2=ALLRED

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything.
  - State becomes GREEN, active_way=0, target=0, timer=0.
  - lights: way0=3'b001, all others=3'b100; phase=0.
  - Reset asserted mid-phase returns to this state on the same edge.
- Outputs are decoded from registered state only. No combinational path from sensor or tick to lights.
- Timer: cleared on every phase change; otherwise +1 on tick, saturating at 2**TW-1.
- other_req = any sensor bit except active_way.
- GREEN -> YELLOW on an edge where all of the following hold:
  - tick=1
  - timer >= MIN_GREEN-1
  - other_req=1
  - sensor[active_way]=0 OR timer >= MAX_GREEN-1
- Behaviour while in GREEN:
  - With no other request, green rests indefinitely, even past MAX_GREEN.
  - A request arriving after MAX_GREEN has elapsed triggers the exit at the next tick.
- target latching:
  - On the GREEN->YELLOW edge, target is latched as the first requesting way searching active_way+1, active_way+2, ... with wrap modulo N_WAYS.
  - target never changes during YELLOW or ALLRED, even if sensors drop.
- YELLOW -> ALLRED on tick when timer == YELLOW_T-1.
- ALLRED -> GREEN on tick when timer == ALLRED_T-1; on this edge active_way <= target.
- lights per phase:
  - GREEN: active way 001.
  - YELLOW: active way 010.
  - ALLRED: every way 100.
  - Non-active ways are always 100.
  - Two ways are never simultaneously non-red.
- tick=0 freezes the timer and the phase. Sensor changes with tick=0 do not transition the phase, but are seen at the next tick.

Optional Feature:
Macro TLC_PREEMPT_EN.
- Defined: adds ports emg_req (in, 1) and emg_way (in, $clog2(N_WAYS)).
  - emg_req=1 in GREEN with active_way != emg_way: go to YELLOW at the next edge regardless of tick or MIN_GREEN, with target=emg_way.
  - emg_req=1 in YELLOW or ALLRED: target is overwritten with emg_way.
  - emg_req=1 in GREEN with active_way==emg_way: green is held and normal exits are suppressed.
  - Yellow and all-red durations are never shortened.
- Undefined: these ports and this logic are absent; behaviour is exactly the base behaviour above.

Decomposition:
- Package tlc_pkg holds:
  - phase encoding constants PH_GREEN=2'd0, PH_YELLOW=2'd1, PH_ALLRED=2'd2
  - lamp constants LAMP_RED=3'b100, LAMP_YELLOW=3'b010, LAMP_GREEN=3'b001
- One sub-module, tlc_rr_pick: combinational round-robin next-requester picker. Inputs: req vector and current index. Outputs: next index and a valid flag.

Test Plan:
All scenarios use defaults (N_WAYS=4, MIN_GREEN=3, MAX_GREEN=6, YELLOW_T=2, ALLRED_T=1) with tick=1 unless stated.
1. Reset, then sensor=4'b0000 for 20 cycles -> way0 lights=001, others 100, phase 0, active_way 0 throughout.
2. After reset, sensor=4'b0100 -> way0 green 3 cycles, yellow 2 cycles, all-red 1 cycle, then active_way=2 with green 001.
3. sensor=4'b0011 held -> way0 green exactly 6 cycles (MAX_GREEN), then yellow; next green is way1. Way1 with sensor=4'b0011 likewise yields to way0 after 6 cycles.
4. Round-robin: from active_way=1 with sensor=4'b1001 -> next is way3. From way3 with sensor=4'b1001 -> next is way0 (wrap). Dropping sensor during yellow does not change target.
5. tick asserted 1 cycle in 4 -> every phase duration is 4x its cycle count. Reset pulsed during YELLOW -> next cycle way0 green, timer 0.
6. With TLC_PREEMPT_EN: way0 green at timer=0, emg_req=1, emg_way=2 -> YELLOW next cycle, then all-red, then way2 green, held green while emg_req stays 1 even with other sensors high.
